// File: rtl/cory_bin_sum.sv
// Decimating binner: accumulates input samples into output bins at an 8.8f
// position step and emits one (sum, count, index, last) word per bin.
module cory_bin_sum #(
  parameter int N = 8,
  parameter int R = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cmd_v,
  input  logic [R-1:0] i_cmd_in_cnt,
  input  logic [R-1:0] i_cmd_out_cnt,
  input  logic [15:0]  i_cmd_ratio,
  output logic         o_cmd_r,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N+8:0] o_z_sum,
  output logic [8:0]   o_z_num,
  output logic [R-1:0] o_z_cnt,
  output logic         o_z_last,
  input  logic         i_z_r
);
  localparam int W  = R + 8;
  localparam int SW = N + 9;
  localparam logic [R-1:0] ONE_R = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  ratio_r, pos_f8, next_f8;
  logic [R-1:0]  in_cnt, out_cnt, in_i, bin;
  logic [SW-1:0] acc;
  logic [8:0]    num;
  logic [15:0]   ratio_cl;
  logic          z_free, a_acc, cmd_acc, last_in, last_bin, close_bin;

  // Decimation only: the step is kept within 1/256..1 bin per sample.
  always_comb begin
    ratio_cl = i_cmd_ratio;
    if (i_cmd_ratio == 16'h0000)
      ratio_cl = 16'h0001;
    else if (i_cmd_ratio > 16'h0100)
      ratio_cl = 16'h0100;
  end

  always_comb begin
    z_free    = !o_z_v || i_z_r;
    o_cmd_r   = (state == IDLE) && !o_z_v;
    o_a_r     = ((state == RUN) && z_free) || (state == DRAIN);
    a_acc     = i_a_v && o_a_r;
    cmd_acc   = i_cmd_v && o_cmd_r;
    next_f8   = pos_f8 + ratio_r;
    last_in   = (in_i == in_cnt - ONE_R);
    last_bin  = (bin == out_cnt - ONE_R);
    close_bin = (next_f8[W-1:8] != pos_f8[W-1:8]) || last_in;
    state_nx  = state;
    unique case (state)
      IDLE: begin
        if (cmd_acc) begin
          if (i_cmd_in_cnt != '0 && i_cmd_out_cnt != '0) state_nx = RUN;
          else if (i_cmd_out_cnt != '0)                   state_nx = FLUSH;
          else if (i_cmd_in_cnt != '0)                    state_nx = DRAIN;
          else                                            state_nx = IDLE;
        end
      end
      RUN: begin
        if (a_acc && close_bin) begin
          if (last_bin)     state_nx = last_in ? IDLE : DRAIN;
          else if (last_in) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (z_free && last_bin) state_nx = IDLE;
      end
      DRAIN: begin
        if (a_acc && last_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_r  <= '0;
      pos_f8   <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      in_i     <= '0;
      bin      <= '0;
      acc      <= '0;
      num      <= '0;
      o_z_v    <= 1'b0;
      o_z_sum  <= '0;
      o_z_num  <= '0;
      o_z_cnt  <= '0;
      o_z_last <= 1'b0;
    end else begin
      if (o_z_v && i_z_r) o_z_v <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_acc) begin
            ratio_r <= W'(ratio_cl);
            in_cnt  <= i_cmd_in_cnt;
            out_cnt <= i_cmd_out_cnt;
            pos_f8  <= '0;
            acc     <= '0;
            num     <= '0;
            in_i    <= '0;
            bin     <= '0;
          end
        end
        RUN: begin
          if (a_acc) begin
            pos_f8 <= next_f8;
            in_i   <= in_i + ONE_R;
            if (close_bin) begin
              o_z_v    <= 1'b1;
              o_z_sum  <= acc + SW'(i_a_d);
              o_z_num  <= num + 9'd1;
              o_z_cnt  <= bin;
              o_z_last <= last_bin;
              acc      <= '0;
              num      <= '0;
              bin      <= bin + ONE_R;
            end else begin
              acc <= acc + SW'(i_a_d);
              num <= num + 9'd1;
            end
          end
        end
        FLUSH: begin
          // Bins no input reached are still emitted, empty, so the consumer sees out_cnt words.
          if (z_free) begin
            o_z_v    <= 1'b1;
            o_z_sum  <= '0;
            o_z_num  <= '0;
            o_z_cnt  <= bin;
            o_z_last <= last_bin;
            bin      <= bin + ONE_R;
          end
        end
        DRAIN: begin
          if (a_acc) in_i <= in_i + ONE_R;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cory_bin_sum.sv
// Directed bench for cory_bin_sum: a floor(i*ratio/256) bin model feeds an
// expected queue that is checked on every output transfer.
module tb_cory_bin_sum;
  localparam int N = 8;
  localparam int R = 11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_cmd_v;
  logic [R-1:0] i_cmd_in_cnt;
  logic [R-1:0] i_cmd_out_cnt;
  logic [15:0]  i_cmd_ratio;
  logic         o_cmd_r;
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic         o_a_r;
  logic         o_z_v;
  logic [N+8:0] o_z_sum;
  logic [8:0]   o_z_num;
  logic [R-1:0] o_z_cnt;
  logic         o_z_last;
  logic         i_z_r;

  cory_bin_sum #(.N(N), .R(R)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_v(i_cmd_v), .i_cmd_in_cnt(i_cmd_in_cnt), .i_cmd_out_cnt(i_cmd_out_cnt),
    .i_cmd_ratio(i_cmd_ratio), .o_cmd_r(o_cmd_r),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_sum(o_z_sum), .o_z_num(o_z_num), .o_z_cnt(o_z_cnt),
    .o_z_last(o_z_last), .i_z_r(i_z_r)
  );

  // clock / reset
  always #5 clk = ~clk;

  // word layout: sum[37:21] num[20:12] cnt[11:1] last[0]
  logic [37:0] exp_q[$];
  logic [37:0] held;
  logic        held_v = 1'b0;
  logic        bp_en = 1'b0;
  logic [7:0]  din[0:511];
  int          msum[0:2047];
  int          mnum[0:2047];
  int          nvec = 0;
  int          errs = 0;
  int          stalls;
  wire  [37:0] zword = {o_z_sum, o_z_num, o_z_cnt, o_z_last};

  function automatic logic [37:0] pack(int s, int n, int c, bit l);
    return {17'(s), 9'(n), 11'(c), l};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: sample i lands in bin floor(i*r/256); bins past out_cnt are dropped,
  // bins never reached are emitted empty.
  task automatic build_model(input int in_c, input int out_c, input int ratio);
    int r, b;
    r = (ratio == 0) ? 1 : ((ratio > 256) ? 256 : ratio);
    for (int k = 0; k < out_c; k++) begin
      msum[k] = 0;
      mnum[k] = 0;
    end
    for (int i = 0; i < in_c; i++) begin
      b = (i * r) / 256;
      if (b < out_c) begin
        msum[b] += int'(din[i]);
        mnum[b] += 1;
      end
    end
    for (int k = 0; k < out_c; k++)
      exp_q.push_back(pack(msum[k], mnum[k], k, k == out_c - 1));
  endtask

  // backpressure driver
  always begin
    @(posedge clk);
    #1;
    i_z_r = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // scoreboard: compare on transfer, check hold while stalled
  always @(negedge clk) begin
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold", {o_z_v, zword}, {1'b1, held});
      if (o_z_v && i_z_r) begin
        if (exp_q.size() == 0) begin
          nvec++;
          errs++;
          $display("FAIL extra_bin: got 0x%0h expected none", zword);
        end else begin
          chk("bin", zword, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else if (o_z_v) begin
        held   = zword;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send_cmd(input int in_c, input int out_c, input int ratio);
    bit hs;
    int n = 0;
    i_cmd_v = 1'b1;
    i_cmd_in_cnt = R'(in_c);
    i_cmd_out_cnt = R'(out_c);
    i_cmd_ratio = 16'(ratio);
    do begin
      @(negedge clk);
      hs = o_cmd_r;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 500);
    i_cmd_v = 1'b0;
    if (!hs) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_sample(input logic [7:0] d);
    bit hs;
    int n = 0;
    i_a_v = 1'b1;
    i_a_d = d;
    do begin
      @(negedge clk);
      hs = o_a_r;
      @(posedge clk);
      #1;
      if (!hs) stalls++;
      n++;
    end while (!hs && n < 500);
    i_a_v = 1'b0;
    if (!hs) chk("a_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_z_v) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic run_case(input int in_c, input int out_c, input int ratio);
    send_cmd(in_c, out_c, ratio);
    for (int i = 0; i < in_c; i++) send_sample(din[i]);
    wait_drain();
  endtask

  task automatic fill_ramp(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) din[i] = 8'(base + i);
  endtask

  initial begin
    reset_n = 1'b0;
    i_cmd_v = 1'b0; i_cmd_in_cnt = '0; i_cmd_out_cnt = '0; i_cmd_ratio = '0;
    i_a_v = 1'b0; i_a_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_r", o_cmd_r, 1);
    chk("rst_a_r", o_a_r, 0);
    chk("rst_z_v", o_z_v, 0);
    chk("rst_zword", zword, 0);
    reset_n = 1'b1;

    // sample valid with no command is ignored
    i_a_v = 1'b1; i_a_d = 8'hAA;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_a_r", o_a_r, 0);
    i_a_v = 1'b0;

    // case 1: 8 -> 4 at half step, back-to-back
    fill_ramp(1, 8);
    build_model(8, 4, 16'h0080);
    chk("model_c1_b0", exp_q[0], pack(3, 2, 0, 0));
    chk("model_c1_b3", exp_q[3], pack(15, 2, 3, 1));
    stalls = 0;
    run_case(8, 4, 16'h0080);
    chk("c1_stalls", stalls, 0);

    // case 2: unit step, then clamped oversize step
    din[0] = 8'd10; din[1] = 8'd20; din[2] = 8'd30;
    build_model(3, 3, 16'h0100);
    chk("model_c2_b2", exp_q[2], pack(30, 1, 2, 1));
    run_case(3, 3, 16'h0100);
    build_model(3, 3, 16'h0300);
    run_case(3, 3, 16'h0300);

    // case 3: inputs run out early, trailing bin flushed empty
    for (int i = 0; i < 4; i++) din[i] = 8'd5;
    build_model(4, 3, 16'h0080);
    chk("model_c3_b2", exp_q[2], pack(0, 0, 2, 1));
    send_cmd(4, 3, 16'h0080);
    for (int i = 0; i < 4; i++) send_sample(din[i]);
    chk("c3_flush_a_r", o_a_r, 0);
    wait_drain();

    // case 4: bins run out early, remaining inputs dropped
    fill_ramp(1, 8);
    build_model(8, 2, 16'h0080);
    chk("model_c4_size", exp_q.size(), 2);
    chk("model_c4_b1", exp_q[1], pack(7, 2, 1, 1));
    send_cmd(8, 2, 16'h0080);
    for (int i = 0; i < 8; i++) begin
      send_sample(din[i]);
      if (i == 6) chk("c4_cmd_r_busy", o_cmd_r, 0);
    end
    chk("c4_cmd_r_done", o_cmd_r, 1);
    wait_drain();

    // case 5: random backpressure
    bp_en = 1'b1;
    fill_ramp(1, 8);
    build_model(8, 4, 16'h0080);
    run_case(8, 4, 16'h0080);
    for (int i = 0; i < 300; i++) din[i] = 8'((i * 7 + 3) & 255);
    build_model(300, 2, 16'h0000);
    chk("model_c5_num0", exp_q[0][20:12], 256);
    chk("model_c5_num1", exp_q[1][20:12], 44);
    chk("model_c5_last1", exp_q[1][0], 1);
    run_case(300, 2, 16'h0000);
    bp_en = 1'b0;

    // case 6: reset mid-command, then a clean rerun
    fill_ramp(1, 8);
    build_model(8, 4, 16'h0080);
    send_cmd(8, 4, 16'h0080);
    for (int i = 0; i < 3; i++) send_sample(din[i]);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_zword", zword, 0);
    chk("mid_rst_z_v", o_z_v, 0);
    chk("mid_rst_cmd_r", o_cmd_r, 1);
    chk("mid_rst_a_r", o_a_r, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    build_model(8, 4, 16'h0080);
    run_case(8, 4, 16'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/cory_bin_sum.md
Name: cory_bin_sum

Overview:
- Decimating counterpart of the tap sampler: the sampler maps input samples onto output positions by padding and repeating; this block maps input samples onto fewer output bins by accumulating.
- Each input sample i belongs to output bin floor(i*ratio/256), with ratio in 8.8f.
- One word per bin is emitted, carrying the raw sum and the sample count; the downstream divider or normaliser consumes sum/num.
- Sits after cory_loop-style data streams in the resize path.

Parameters:
N, 8, natural data bits
R, 11, resolution bits for counts and bin index

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_cmd_v  input  1  command valid
i_cmd_in_cnt  input  R  input samples in the line (1 for 1)
i_cmd_out_cnt  input  R  bins to emit (1 for 1)
i_cmd_ratio  input  16  8.8f output-position step per input sample
o_cmd_r  output  1  command ready
i_a_v  input  1  input sample valid
i_a_d  input  N  input sample
o_a_r  output  1  input ready
o_z_v  output  1  bin valid
o_z_sum  output  N+9  sum of samples in bin
o_z_num  output  9  samples in bin (0..256)
o_z_cnt  output  R  bin index
o_z_last  output  1  final bin of command
i_z_r  input  1  bin ready

Behaviour:
- Single clock clk; reset is asynchronous, active-low on reset_n.
- Reset values:
  - State IDLE; o_cmd_r=1; o_a_r=0; o_z_v=0.
  - o_z_sum=0, o_z_num=0, o_z_cnt=0, o_z_last=0.
  - Accumulator, counters and position register all 0.
- Handshakes: a transfer occurs on v&r. Once v is raised it holds until the transfer. o_z_* are registered and stable while o_z_v=1 and i_z_r=0.
- Ratio clamp at command accept: 0 becomes 0x0001; values above 0x0100 become 0x0100 (decimation only). The clamped ratio is latched with both counts.
- FSM:
  - IDLE: o_cmd_r=1. On cmd transfer: pos_f8<=0, acc<=0, num<=0, in_i<=0, bin<=0.
    - Next state: RUN if in_cnt!=0 and out_cnt!=0; FLUSH if in_cnt==0 and out_cnt!=0; DRAIN if out_cnt==0 and in_cnt!=0; IDLE if both are 0.
  - RUN: o_a_r = !o_z_v | i_z_r, so the single output register may be overwritten in the cycle it drains.
    - Per accepted sample: next_f8 = pos_f8 + ratio (R+8 bits, wraps), in_i++.
    - Bin closes if next_f8[R+7:8] != pos_f8[R+7:8], or if in_i == in_cnt-1.
    - On close: o_z_sum<=acc+d, o_z_num<=num+1, o_z_cnt<=bin, o_z_last<=(bin==out_cnt-1), o_z_v<=1; then acc<=0, num<=0, bin++.
    - Otherwise: acc+=d, num++.
    - pos_f8<=next_f8 on every accept.
  - RUN exits:
    - If the closing bin is out_cnt-1 and inputs remain, go DRAIN.
    - If the closing bin is out_cnt-1 and this is the last input, go IDLE once o_z_v is cleared.
    - If the last input closes a bin below out_cnt-1, go FLUSH.
  - FLUSH: emits the remaining bins bin..out_cnt-1 with sum=0, num=0 (one per o_z transfer, o_z_last on the final one), then goes to IDLE.
  - DRAIN: o_a_r=1; remaining inputs are accepted and dropped with no output. Goes to IDLE after the input with in_i==in_cnt-1. A pending o_z word still completes normally.
- o_cmd_r=1 only in IDLE with o_z_v=0 (the prior command has fully retired).
- Throughput: one input per cycle in RUN while the downstream keeps up. Latency from closing input transfer to o_z_v is 1 cycle.
- Boundary cases:
  - i_a_v without a command is ignored (o_a_r=0).
  - Holding i_z_r=0 stalls o_a_r at 0 once the output register is full.
  - num never exceeds 256; the sum width N+9 therefore cannot overflow.
- Asynchronous reset mid-command aborts immediately to reset values; any partial bin is lost.

Test Plan:
- N=8. cmd in=8, out=4, ratio=0x0080; inputs 1..8 -> bins (3,2,0,0) (7,2,1,0) (11,2,2,0) (15,2,3,1) as (sum,num,cnt,last); back-to-back inputs with i_z_r=1 give one bin every 2 cycles with o_a_r never low.
- cmd in=3, out=3, ratio=0x0100; inputs 10,20,30 -> bins (10,1),(20,1),(30,1); ratio 0x0300 is clamped and yields the identical result.
- cmd in=4, out=3, ratio=0x0080; inputs 5,5,5,5 -> (10,2,0),(10,2,1), then FLUSH (0,0,2,last=1); o_a_r=0 during FLUSH.
- cmd in=8, out=2, ratio=0x0080; inputs 1..8 -> (3,2,0),(7,2,1,last); inputs 5..8 accepted and dropped; o_cmd_r returns to 1 only after the 8th input.
- Backpressure: random i_z_r with 30% duty on the first case -> identical bin sequence, o_z_* stable while stalled, no input lost; ratio=0 on in=300, out=2 -> bin0 (num=256), bin1 (num=44, last).
- Reset asserted after the 3rd input of the first case -> all outputs are 0 immediately and o_cmd_r=1; the next command runs cleanly from bin 0.
